ninjakun_vram_arb: RTL

//  Shares one single-port 1Kx16 FG or BG VRAM between two requesters:
//  - the CPU byte port: Z80 side, stalled with WAIT.
//  - the scanline fetcher's 16-bit tile read: FGVAD/FGVDT or BGVAD/BGVDT.
//  One instance sits per VRAM, between the CPU bus decode and the NINJAKUN_FG/NINJAKUN_BG generators.

---
 rtl/ninjakun_vram_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ninjakun_vram_arb.sv
// ninjakun_vram_arb
//   Time-shares one single-port 1Kx16 VRAM (FG or BG) between the Z80 byte
//   port and the scanline tile fetcher. A video request in a pixel-phase-0
//   cycle always owns the RAM. Every other cycle is available to the CPU,
//   which is held off with WAIT until its byte has been read or written.
//
// Ports
//   i_vclkx4    clock, four cycles per pixel
//   i_reset_n   asynchronous active-low reset
//   i_pixce     pixel phase 0 marker (one cycle in four)
//   i_vid_rq    video read request, qualified by i_pixce
//   i_vid_ad    video word address
//   o_vid_dt    latched video read data
//   i_cpu_rq    CPU request level, held until o_cpu_wait drops
//   i_cpu_wr    CPU write (1) / read (0), sampled at grant
//   i_cpu_ad    CPU byte address, bit 0 selects high/low byte
//   i_cpu_di    CPU write data
//   o_cpu_do    CPU read data (registered)
//   o_cpu_wait  CPU stall
//   o_ram_ad    VRAM word address
//   o_ram_we    VRAM write strobe
//   o_ram_be    VRAM byte enables, bit1 = high byte, bit0 = low byte
//   o_ram_di    VRAM write data
//   i_ram_do    VRAM read data, valid the cycle after its address
module ninjakun_vram_arb #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          i_vclkx4,
  input  logic          i_reset_n,
  input  logic          i_pixce,
  input  logic          i_vid_rq,
  input  logic [AW-1:0] i_vid_ad,
  output logic [DW-1:0] o_vid_dt,
  input  logic          i_cpu_rq,
  input  logic          i_cpu_wr,
  input  logic [AW:0]   i_cpu_ad,
  input  logic [7:0]    i_cpu_di,
  output logic [7:0]    o_cpu_do,
  output logic          o_cpu_wait,
  output logic [AW-1:0] o_ram_ad,
  output logic          o_ram_we,
  output logic [1:0]    o_ram_be,
  output logic [DW-1:0] o_ram_di,
  input  logic [DW-1:0] i_ram_do
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_vslot;
  logic          w_grant;
  logic          r_bsel;
  logic          r_wr;
  logic          r_vpend;
  logic [DW-1:0] r_vid_dt;
  logic [7:0]    r_cpu_do;

  // A video request in pixel phase 0 owns the RAM; the CPU can only be
  // granted from IDLE in a cycle that is not a video slot.
  assign w_vslot = i_pixce & i_vid_rq;
  assign w_grant = (r_state == ST_IDLE) & i_cpu_rq & ~w_vslot;

  // State register
  always_ff @(posedge i_vclkx4 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. DONE is left only once the CPU drops its request,
  // so a held request can never start a second access.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_next = ST_ACC;
      ST_ACC:  w_next = ST_DONE;
      ST_DONE: if (!i_cpu_rq) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic. Address, byte enables and write data follow the CPU bus
  // whenever video does not own the cycle; only the write strobe is
  // qualified, and it is killed outright while reset is asserted.
  always_comb begin
    o_ram_ad   = w_vslot ? i_vid_ad : i_cpu_ad[AW:1];
    o_ram_we   = w_grant & i_cpu_wr & i_reset_n;
    o_ram_be   = i_cpu_ad[0] ? 2'b10 : 2'b01;
    o_ram_di   = {i_cpu_di, i_cpu_di};
    o_cpu_wait = i_cpu_rq & (r_state != ST_DONE);
  end

  // Access attributes are captured at grant so later bus changes cannot
  // affect the access in flight.
  always_ff @(posedge i_vclkx4 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bsel <= 1'b0;
      r_wr   <= 1'b0;
    end else if (w_grant) begin
      r_bsel <= i_cpu_ad[0];
      r_wr   <= i_cpu_wr;
    end
  end

  // CPU read data is taken from the RAM output in ACC, which always carries
  // the CPU's own word even if a video slot follows the grant.
  always_ff @(posedge i_vclkx4 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cpu_do <= 8'h00;
    end else if ((r_state == ST_ACC) && !r_wr) begin
      r_cpu_do <= r_bsel ? i_ram_do[15:8] : i_ram_do[7:0];
    end
  end

  // Video read data appears one cycle after the slot; r_vpend marks that
  // cycle so the word is captured there and held until the next slot.
  always_ff @(posedge i_vclkx4 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_vpend  <= 1'b0;
      r_vid_dt <= '0;
    end else begin
      r_vpend <= w_vslot;
      if (r_vpend) begin
        r_vid_dt <= i_ram_do;
      end
    end
  end

  assign o_vid_dt = r_vid_dt;
  assign o_cpu_do = r_cpu_do;

endmodule
